// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM with a mem_ready handshake and a sticky stall watchdog.
// Optional BNE decode is enabled by defining BNE_EN.
module multicycle_control_unit #(
  parameter int ALU_OP_W    = 2,
  parameter int STALL_LIMIT = 15,
  parameter int CNT_W       = 4
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic [5:0]          opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_source,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_2_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                instr_done,
  output logic                illegal_op,
  output logic                mem_timeout
`ifdef BNE_EN
  ,
  output logic                branch_ne
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_R   = ALU_OP_W'(2);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);

  typedef enum logic [3:0] {
    S_IF, S_ID, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_R_EX, S_R_WB, S_BR, S_JMP, S_ADDI_EX, S_ADDI_WB, S_BNE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] stall_cnt, stall_cnt_nxt;
  logic             waiting;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= S_IF;
      stall_cnt   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      stall_cnt   <= stall_cnt_nxt;
      mem_timeout <= mem_timeout | (stall_cnt_nxt == LIMIT);
    end
  end

  // Watchdog only observes the three handshake states; it never aborts the wait.
  assign waiting = (state == S_IF) || (state == S_MEM_RD) || (state == S_MEM_WR);

  always_comb begin
    stall_cnt_nxt = '0;
    if (waiting && !mem_ready)
      stall_cnt_nxt = (stall_cnt == LIMIT) ? stall_cnt : stall_cnt + 1'b1;
  end

  always_comb begin
    state_nxt     = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'd0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_2_reg     = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = ALU_ADD;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
`ifdef BNE_EN
    branch_ne     = 1'b0;
`endif
    case (state)
      S_IF: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_nxt = S_ID;
      end
      S_ID: begin
        alu_src_b = 2'd3;
        case (opcode)
          OP_RTYPE:      state_nxt = S_R_EX;
          OP_ADDI:       state_nxt = S_ADDI_EX;
          OP_LW, OP_SW:  state_nxt = S_MEM_ADDR;
          OP_BEQ:        state_nxt = S_BR;
          OP_J:          state_nxt = S_JMP;
`ifdef BNE_EN
          OP_BNE:        state_nxt = S_BNE;
`endif
          default: begin
            illegal_op = 1'b1;
            state_nxt  = S_IF;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        mem_2_reg  = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_IF;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_nxt = S_IF;
      end
      S_R_EX: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_R;
        state_nxt = S_R_WB;
      end
      S_R_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_IF;
      end
      S_BR, S_BNE: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
        instr_done    = 1'b1;
`ifdef BNE_EN
        branch_ne     = (state == S_BNE);
`endif
        state_nxt     = S_IF;
      end
      S_JMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'd2;
        instr_done = 1'b1;
        state_nxt  = S_IF;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_nxt = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_IF;
      end
      default: state_nxt = S_IF;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Table-driven bench for multicycle_control_unit: per-cycle vectors with expected state,
// expected output words queued on drive and popped on sample.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_2_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op, mem_timeout;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic       bne_out;

  always #5 clk = ~clk;

  multicycle_control_unit #(.ALU_OP_W(2), .STALL_LIMIT(15), .CNT_W(4)) dut (
    .clk(clk), .arst_n(arst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_2_reg(mem_2_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .instr_done(instr_done), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
`ifdef BNE_EN
    , .branch_ne(bne_out)
`endif
  );

`ifndef BNE_EN
  assign bne_out = 1'b0;
`endif

  typedef enum {T_IF, T_ID, T_MEM_ADDR, T_MEM_RD, T_MEM_WB, T_MEM_WR,
                T_R_EX, T_R_WB, T_BR, T_JMP, T_ADDI_EX, T_ADDI_WB, T_BNE} tst_e;

  typedef struct packed {
    logic       pc_write, pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d, mem_read, mem_write, ir_write, mem_2_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       instr_done, illegal_op, mem_timeout, branch_ne;
  } out_t;

  typedef struct {
    tst_e       st;
    logic [5:0] op;
    logic       rdy;
    logic       to;
  } vec_t;

  vec_t vecs[$];
  out_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic legal(logic [5:0] op);
    legal = (op == 6'h00) || (op == 6'h08) || (op == 6'h23) || (op == 6'h2B) ||
            (op == 6'h04) || (op == 6'h02);
`ifdef BNE_EN
    if (op == 6'h05) legal = 1'b1;
`endif
  endfunction

  // Expected strobes per state, written out from the control table.
  function automatic out_t expect_out(tst_e s, logic [5:0] op, logic rdy, logic to);
    out_t o = '0;
    o.mem_timeout = to;
    case (s)
      T_IF:       begin o.mem_read = 1; o.alu_src_b = 1; o.ir_write = rdy; o.pc_write = rdy; end
      T_ID:       begin o.alu_src_b = 3; o.illegal_op = !legal(op); end
      T_MEM_ADDR: begin o.alu_src_a = 1; o.alu_src_b = 2; end
      T_MEM_RD:   begin o.mem_read = 1; o.i_or_d = 1; end
      T_MEM_WB:   begin o.mem_2_reg = 1; o.reg_write = 1; o.instr_done = 1; end
      T_MEM_WR:   begin o.mem_write = 1; o.i_or_d = 1; o.instr_done = rdy; end
      T_R_EX:     begin o.alu_src_a = 1; o.alu_op = 2; end
      T_R_WB:     begin o.reg_dst = 1; o.reg_write = 1; o.instr_done = 1; end
      T_BR, T_BNE: begin
        o.alu_src_a = 1; o.alu_op = 1; o.pc_write_cond = 1; o.pc_source = 1;
        o.instr_done = 1; o.branch_ne = (s == T_BNE);
      end
      T_JMP:      begin o.pc_write = 1; o.pc_source = 2; o.instr_done = 1; end
      T_ADDI_EX:  begin o.alu_src_a = 1; o.alu_src_b = 2; end
      T_ADDI_WB:  begin o.reg_write = 1; o.instr_done = 1; end
      default:    o = '0;
    endcase
    return o;
  endfunction

  function automatic out_t actual();
    out_t o;
    o = '{pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
          mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
          instr_done, illegal_op, mem_timeout, bne_out};
    return o;
  endfunction

  task automatic compare(string name);
    out_t e, a;
    e = sb.pop_front();
    a = actual();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, a, e);
    end
  endtask

  // One cycle: drive at negedge, queue expectation, sample before the next posedge.
  task automatic apply(vec_t v, int idx);
    @(negedge clk);
    opcode    = v.op;
    mem_ready = v.rdy;
    sb.push_back(expect_out(v.st, v.op, v.rdy, v.to));
    #1;
    compare($sformatf("vec%0d_st%0d", idx, v.st));
  endtask

  function automatic void add(tst_e s, logic [5:0] op, logic rdy, logic to);
    vec_t v;
    v.st = s; v.op = op; v.rdy = rdy; v.to = to;
    vecs.push_back(v);
  endfunction

  initial begin
    // R-type
    add(T_IF, 6'h00, 1, 0); add(T_ID, 6'h00, 0, 0); add(T_R_EX, 6'h00, 0, 0); add(T_R_WB, 6'h00, 0, 0);
    // LW with three memory wait states
    add(T_IF, 6'h23, 1, 0); add(T_ID, 6'h23, 0, 0); add(T_MEM_ADDR, 6'h23, 1, 0);
    add(T_MEM_RD, 6'h3F, 0, 0); add(T_MEM_RD, 6'h3F, 0, 0); add(T_MEM_RD, 6'h3F, 0, 0);
    add(T_MEM_RD, 6'h3F, 1, 0); add(T_MEM_WB, 6'h3F, 0, 0);
    // SW, one wait state, then SW with none
    add(T_IF, 6'h2B, 1, 0); add(T_ID, 6'h2B, 0, 0); add(T_MEM_ADDR, 6'h2B, 0, 0);
    add(T_MEM_WR, 6'h00, 0, 0); add(T_MEM_WR, 6'h00, 1, 0);
    add(T_IF, 6'h2B, 1, 0); add(T_ID, 6'h2B, 1, 0); add(T_MEM_ADDR, 6'h2B, 1, 0); add(T_MEM_WR, 6'h2B, 1, 0);
    // BEQ, J, ADDI
    add(T_IF, 6'h04, 1, 0); add(T_ID, 6'h04, 0, 0); add(T_BR, 6'h00, 1, 0);
    add(T_IF, 6'h02, 1, 0); add(T_ID, 6'h02, 0, 0); add(T_JMP, 6'h00, 1, 0);
    add(T_IF, 6'h08, 1, 0); add(T_ID, 6'h08, 0, 0); add(T_ADDI_EX, 6'h00, 0, 0); add(T_ADDI_WB, 6'h00, 0, 0);
    // Illegal opcode returns to fetch
    add(T_IF, 6'h3F, 1, 0); add(T_ID, 6'h3F, 1, 0); add(T_IF, 6'h3F, 1, 0);
    // 0x05: BNE when enabled, otherwise illegal
    add(T_ID, 6'h05, 0, 0);
`ifdef BNE_EN
    add(T_BNE, 6'h00, 0, 0);
`endif
    // Fetch stall: flag rises after the 15th stalled cycle and stays set
    for (int i = 0; i < 15; i++) add(T_IF, 6'h00, 0, 0);
    add(T_IF, 6'h00, 1, 1); add(T_ID, 6'h00, 0, 1); add(T_R_EX, 6'h00, 0, 1); add(T_R_WB, 6'h00, 0, 1);
    // SW into MEM_WR for the async reset case
    add(T_IF, 6'h2B, 1, 1); add(T_ID, 6'h2B, 0, 1); add(T_MEM_ADDR, 6'h2B, 0, 1); add(T_MEM_WR, 6'h2B, 0, 1);

    // Reset state with mem_ready low
    #3;
    sb.push_back(expect_out(T_IF, 6'h00, 0, 0));
    compare("reset_state");
    @(negedge clk);
    arst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i], i);

    // Asynchronous reset mid-write: strobes drop at once, flag clears
    #2;
    arst_n = 1'b0;
    #1;
    sb.push_back(expect_out(T_IF, 6'h00, 0, 0));
    compare("async_reset_in_mem_wr");
    checks++;
    if (mem_write !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_mem_write got %b expected 0", mem_write);
    end
    @(negedge clk);
    arst_n = 1'b1;
    begin
      vec_t v;
      v.st = T_IF; v.op = 6'h08; v.rdy = 1; v.to = 0; apply(v, 1000);
      v.st = T_ID;                                     apply(v, 1001);
      v.st = T_ADDI_EX;                                apply(v, 1002);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Sequential control FSM for the multi-cycle MIPS datapath. It is the successor to the single-cycle decoder. It sequences fetch, decode, execute, memory and writeback per instruction, and drives one-hot-per-state datapath strobes. It also supports variable-latency memory through a mem_ready handshake with a stall watchdog. It sits between the instruction register opcode field and the shared-memory multi-cycle datapath.

Parameters:
ALU_OP_W, 2, width of alu_op; encodings ADD=0, SUB=1, R_TYPE=2, zero-extended to this width
STALL_LIMIT, 15, consecutive cycles spent waiting on mem_ready before mem_timeout is raised; must be >=1
CNT_W, 4, stall counter width; must hold STALL_LIMIT

Ports:
clk  in  1  system clock, rising edge
arst_n  in  1  asynchronous active-low reset
opcode  in  6  instr[31:26] from the instruction register; sampled in ID
mem_ready  in  1  memory completed the current read/write this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero (branch)
pc_source  out  2  0=ALU result, 1=ALUOut (branch target), 2=jump target
i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  instruction register load
mem_2_reg  out  1  writeback data select: 1=MDR, 0=ALUOut
reg_dst  out  1  1=rd, 0=rt
reg_write  out  1  register file write enable
alu_src_a  out  1  0=PC, 1=A
alu_src_b  out  2  0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
alu_op  out  ALU_OP_W  ALU control class
instr_done  out  1  one-cycle pulse in the final state of each instruction
illegal_op  out  1  one-cycle pulse on an undecodable opcode
mem_timeout  out  1  sticky flag; cleared only by reset

Behaviour:
- States: IF, ID, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EX, R_WB, BR, JMP, ADDI_EX, ADDI_WB. Registered state; all outputs combinational from state (plus mem_ready where noted). Unlisted outputs are 0 in every state.
- Reset (async, arst_n=0): state=IF, stall counter=0, mem_timeout=0. Every output takes its IF value with mem_ready=0: mem_read=1, alu_src_b=1, all others 0.
- IF: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_source=0.
  - ir_write=pc_write=mem_ready.
  - Stay in IF until mem_ready, then go to ID.
- ID: alu_src_a=0, alu_src_b=3, alu_op=ADD. Next state by opcode:
  - 0x00 -> R_EX
  - 0x08 -> ADDI_EX
  - 0x23 or 0x2B -> MEM_ADDR
  - 0x04 -> BR
  - 0x02 -> JMP
  - any other opcode -> pulse illegal_op, go to IF (no architectural side effect).
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=ADD. Opcode 0x23 -> MEM_RD, 0x2B -> MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Wait for mem_ready, then go to MEM_WB.
- MEM_WB: reg_dst=0, mem_2_reg=1, reg_write=1, instr_done=1 -> IF.
- MEM_WR: mem_write=1, i_or_d=1, instr_done=mem_ready. Wait for mem_ready, then go to IF.
- R_EX: alu_src_a=1, alu_src_b=0, alu_op=R_TYPE -> R_WB.
- R_WB: reg_dst=1, reg_write=1, mem_2_reg=0, instr_done=1 -> IF.
- BR: alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_write_cond=1, pc_source=1, instr_done=1 -> IF.
- JMP: pc_write=1, pc_source=2, instr_done=1 -> IF.
- ADDI_EX: alu_src_a=1, alu_src_b=2, alu_op=ADD -> ADDI_WB.
- ADDI_WB: reg_dst=0, mem_2_reg=0, reg_write=1, instr_done=1 -> IF.
- Latency with zero memory wait states: R-type/ADDI 4 cycles, LW 5, SW 4, BEQ 3, J 3.
- Stall counter:
  - Increments in IF/MEM_RD/MEM_WR on each cycle with mem_ready=0, saturating at STALL_LIMIT.
  - Clears on mem_ready=1 and on leaving those states.
  - When it equals STALL_LIMIT, mem_timeout is set (sticky). The FSM keeps waiting and does not abort.
- mem_ready is ignored outside IF/MEM_RD/MEM_WR.
- Reset asserted mid-instruction abandons it immediately; no write strobe may glitch high during reset.
- opcode is don't-care outside ID/MEM_ADDR.

Optional Feature:
BNE_EN:
- Defined: opcode 0x05 decodes in ID to state BNE. BNE drives the same signals as BR plus output branch_ne=1 (port present only when defined), so the datapath inverts its zero condition; instr_done=1 -> IF.
- Undefined: 0x05 is illegal (illegal_op pulse), and no branch_ne port exists.

Test Plan:
- Reset held, then released with mem_ready=1 and opcode=0x00 -> reset outputs as specified; IF,ID,R_EX,R_WB; reg_write=1 and reg_dst=1 in cycle 4; instr_done pulses once.
- LW (0x23) with mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles; reg_write+mem_2_reg in MEM_WB; mem_timeout stays 0.
- SW (0x2B), mem_ready=1 -> mem_write=1, i_or_d=1 for exactly 1 cycle; reg_write never 1; 4 cycles total.
- IF with mem_ready=0 for 15 cycles -> mem_timeout=1 from the 15th stall; then mem_ready=1 completes fetch; flag stays 1 until arst_n=0.
- opcode=0x3F -> illegal_op 1-cycle pulse in ID; next state IF; no pc_write/reg_write/mem_write. With BNE_EN, opcode=0x05 -> BNE, branch_ne=1, pc_write_cond=1.
- arst_n dropped asynchronously in MEM_WR -> mem_write drops immediately; state IF.
